axis_s_buf: RTL and testbench

AXIS_S_BUF -- requirements
Module: axis_s_buf

---
 rtl/axis_pkg.sv | 16 +
 rtl/axis_buf_mem.sv | 28 ++
 rtl/axis_s_buf.sv | 130 +++++++++++++
 tb/tb_axis_s_buf.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions: default stream width and the stored beat layout.
package axis_pkg;

   localparam int AXIS_DATA_W = 32;

   typedef struct packed {
      logic                   last;
      logic [AXIS_DATA_W-1:0] data;
   } axis_beat_t;

   // Occupancy counter width: must hold the value DEPTH itself, not just DEPTH-1.
   function automatic int level_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/axis_buf_mem.sv
// Beat storage for axis_s_buf: one synchronous write port, one asynchronous read port.
module axis_buf_mem
   import axis_pkg::*;
#(
   parameter  int DATA_W = AXIS_DATA_W,
   parameter  int DEPTH  = 4,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              aclk,
   input  logic              wr_en_i,
   input  logic [AW-1:0]     wr_addr_i,
   input  logic [DATA_W:0]   wr_beat_i,
   input  logic [AW-1:0]     rd_addr_i,
   output logic [DATA_W:0]   rd_beat_o
);

   // Contents are never reset; validity is tracked by the owner's level counter.
   logic [DATA_W:0] mem_q [DEPTH];

   always_ff @(posedge aclk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_beat_i;
      end
   end

   assign rd_beat_o = mem_q[rd_addr_i];

endmodule

// File: rtl/axis_s_buf.sv
// AXI-Stream slave into a first-word-fall-through FIFO, with a packet counter and
// a sticky checker for upstream handshake violations (beat withdrawn or altered while stalled).
module axis_s_buf
   import axis_pkg::*;
#(
   parameter int DATA_W = AXIS_DATA_W,
   parameter int DEPTH  = 4
) (
   input  logic                       aclk,
   input  logic                       areset_n,
   input  logic                       s_tvalid,
   output logic                       s_tready,
   input  logic [DATA_W-1:0]          s_tdata,
   input  logic                       s_tlast,
   input  logic                       rd_en,
   output logic                       rd_valid,
   output logic [DATA_W-1:0]          rd_data,
   output logic                       rd_last,
   output logic [level_w(DEPTH)-1:0]  level,
   output logic [15:0]                pkt_cnt,
   output logic                       proto_err,
   input  logic                       clr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = level_w(DEPTH);
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic [15:0]       pkt_cnt_q, pkt_cnt_d;
   logic              stalled_q, stalled_d;
   logic [DATA_W-1:0] stall_data_q;
   logic              proto_err_q, proto_err_d;

   logic              wr_fire;
   logic              rd_fire;
   logic              err_set;
   logic [DATA_W:0]   wr_beat;
   logic [DATA_W:0]   rd_beat;

   // Flow control looks only at registered state, so s_tready never depends on s_tvalid
   // and a slot freed by a read is offered one cycle later.
   assign s_tready = (level_q != FULL_LVL);
   assign rd_valid = (level_q != '0);

   assign wr_fire = s_tvalid & s_tready;
   assign rd_fire = rd_en & rd_valid;
   assign wr_beat = {s_tlast, s_tdata};

   axis_buf_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .aclk      (aclk),
      .wr_en_i   (wr_fire),
      .wr_addr_i (wr_ptr_q),
      .wr_beat_i (wr_beat),
      .rd_addr_i (rd_ptr_q),
      .rd_beat_o (rd_beat)
   );

   assign rd_last = rd_beat[DATA_W];
   assign rd_data = rd_beat[DATA_W-1:0];

   // A beat that was stalled last cycle must still be offered, unchanged.
   assign err_set = stalled_q & (~s_tvalid | (s_tdata != stall_data_q));

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      pkt_cnt_d   = pkt_cnt_q;
      stalled_d   = s_tvalid & ~s_tready;
      proto_err_d = proto_err_q;

      if (wr_fire) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         if (s_tlast) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
         end
      end

      if (rd_fire) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      case ({wr_fire, rd_fire})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      // A fresh violation outranks a clear arriving in the same cycle.
      if (err_set) begin
         proto_err_d = 1'b1;
      end else if (clr_err) begin
         proto_err_d = 1'b0;
      end
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         pkt_cnt_q   <= '0;
         stalled_q   <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         pkt_cnt_q   <= pkt_cnt_d;
         stalled_q   <= stalled_d;
         proto_err_q <= proto_err_d;
      end
   end

   // Captured every cycle; only meaningful when stalled_q is set.
   always_ff @(posedge aclk) begin
      stall_data_q <= s_tdata;
   end

   assign level     = level_q;
   assign pkt_cnt   = pkt_cnt_q;
   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_axis_s_buf.sv
// Randomized and directed bench for axis_s_buf against a queue-based reference model.
module tb_axis_s_buf;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;
   localparam int LW     = 3;

   logic              aclk      = 1'b0;
   logic              areset_n  = 1'b0;
   logic              s_tvalid  = 1'b0;
   logic [DATA_W-1:0] s_tdata   = '0;
   logic              s_tlast   = 1'b0;
   logic              rd_en     = 1'b0;
   logic              clr_err   = 1'b0;
   logic              s_tready;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              rd_last;
   logic [LW-1:0]     level;
   logic [15:0]       pkt_cnt;
   logic              proto_err;

   axis_s_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .aclk      (aclk),
      .areset_n  (areset_n),
      .s_tvalid  (s_tvalid),
      .s_tready  (s_tready),
      .s_tdata   (s_tdata),
      .s_tlast   (s_tlast),
      .rd_en     (rd_en),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .rd_last   (rd_last),
      .level     (level),
      .pkt_cnt   (pkt_cnt),
      .proto_err (proto_err),
      .clr_err   (clr_err)
   );

   always #5 aclk = ~aclk;

   // Reference model: FIFO contents as a queue of {last, data}.
   logic [DATA_W:0]   m_q[$];
   logic [15:0]       m_pkt;
   bit                m_err;
   bit                m_pstall;
   logic [DATA_W-1:0] m_pdata;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pkt    = '0;
      m_err    = 1'b0;
      m_pstall = 1'b0;
      m_pdata  = '0;
   endtask

   task automatic model_edge();
      bit full, wr, rd, set;
      full = (m_q.size() == DEPTH);
      wr   = s_tvalid && !full;
      rd   = rd_en && (m_q.size() != 0);
      set  = m_pstall && (!s_tvalid || (s_tdata != m_pdata));
      if (rd) void'(m_q.pop_front());
      if (wr) begin
         m_q.push_back({s_tlast, s_tdata});
         if (s_tlast) m_pkt = m_pkt + 16'd1;
      end
      if (set) m_err = 1'b1;
      else if (clr_err) m_err = 1'b0;
      m_pstall = s_tvalid && full;
      m_pdata  = s_tdata;
   endtask

   task automatic compare_model();
      expect_eq("s_tready", s_tready, m_q.size() != DEPTH);
      expect_eq("rd_valid", rd_valid, m_q.size() != 0);
      expect_eq("level", level, m_q.size());
      expect_eq("pkt_cnt", pkt_cnt, m_pkt);
      expect_eq("proto_err", proto_err, m_err);
      if (m_q.size() != 0) begin
         expect_eq("rd_data", rd_data, m_q[0][DATA_W-1:0]);
         expect_eq("rd_last", rd_last, m_q[0][DATA_W]);
      end
   endtask

   // Called at a falling edge with inputs already set; returns at the next falling edge.
   task automatic tick(input bit do_chk);
      if (do_chk) compare_model();
      @(posedge aclk);
      model_edge();
      @(negedge aclk);
   endtask

   task automatic idle_inputs();
      s_tvalid = 1'b0;
      s_tdata  = '0;
      s_tlast  = 1'b0;
      rd_en    = 1'b0;
      clr_err  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge aclk);
      idle_inputs();
      areset_n = 1'b0;
      model_reset();
      #1;
      expect_eq("rst_level", level, 0);
      expect_eq("rst_rd_valid", rd_valid, 0);
      expect_eq("rst_s_tready", s_tready, 1);
      expect_eq("rst_pkt_cnt", pkt_cnt, 0);
      expect_eq("rst_proto_err", proto_err, 0);
      @(negedge aclk);
      areset_n = 1'b1;
   endtask

   initial begin
      int guard;
      model_reset();

      // Single beat, first-word-fall-through after one edge.
      do_reset();
      s_tvalid = 1'b1; s_tdata = 32'hA5A5_0001; s_tlast = 1'b1;
      tick(1);
      idle_inputs();
      expect_eq("single_rd_valid", rd_valid, 1);
      expect_eq("single_rd_data", rd_data, 32'hA5A5_0001);
      expect_eq("single_rd_last", rd_last, 1);
      expect_eq("single_level", level, 1);
      expect_eq("single_pkt_cnt", pkt_cnt, 1);
      tick(1);

      // Five back-to-back beats into a four-deep buffer.
      do_reset();
      s_tvalid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         s_tdata = i;
         tick(1);
      end
      s_tdata = 5;
      expect_eq("full_level", level, 4);
      expect_eq("full_s_tready", s_tready, 0);
      tick(1);
      expect_eq("held_level", level, 4);
      rd_en = 1'b1;
      expect_eq("full_rd_s_tready", s_tready, 0);
      tick(1);
      rd_en = 1'b0;
      expect_eq("after_pop_level", level, 3);
      expect_eq("after_pop_head", rd_data, 2);
      expect_eq("after_pop_s_tready", s_tready, 1);
      tick(1);
      s_tvalid = 1'b0;
      expect_eq("beat5_level", level, 4);
      expect_eq("beat5_proto_err", proto_err, 0);
      tick(1);

      // Steady state: simultaneous write and read keep the level and the order.
      do_reset();
      s_tvalid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         s_tdata = 100 + i;
         tick(1);
      end
      rd_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         s_tdata = 102 + i;
         expect_eq("stream_level", level, 2);
         expect_eq("stream_order", rd_data, 100 + i);
         tick(1);
      end
      idle_inputs();
      tick(1);

      // Data changed while stalled, then withdrawn; error is sticky until cleared.
      do_reset();
      s_tvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_tdata = i;
         tick(1);
      end
      s_tdata = 32'h10;
      tick(1);
      expect_eq("stall_no_err", proto_err, 0);
      s_tdata = 32'h11;
      tick(1);
      expect_eq("changed_err", proto_err, 1);
      s_tvalid = 1'b0;
      tick(1);
      tick(1);
      expect_eq("sticky_err", proto_err, 1);
      clr_err = 1'b1;
      tick(1);
      clr_err = 1'b0;
      expect_eq("cleared_err", proto_err, 0);
      expect_eq("err_buf_level", level, 4);
      tick(1);

      // Packet counter wrap.
      do_reset();
      s_tvalid = 1'b1; s_tlast = 1'b1; rd_en = 1'b1;
      guard = 0;
      while (m_pkt != 16'hFFFF && guard < 70000) begin
         s_tdata = guard;
         tick(0);
         guard++;
      end
      expect_eq("pkt_preload", pkt_cnt, 16'hFFFF);
      tick(1);
      expect_eq("pkt_wrap", pkt_cnt, 16'h0000);
      idle_inputs();
      tick(1);

      // Asynchronous reset with entries in flight.
      do_reset();
      s_tvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s_tdata = 32'h300 + i;
         tick(1);
      end
      expect_eq("pre_arst_level", level, 3);
      #2;
      areset_n = 1'b0;
      model_reset();
      #1;
      expect_eq("arst_level", level, 0);
      expect_eq("arst_rd_valid", rd_valid, 0);
      expect_eq("arst_s_tready", s_tready, 1);
      @(negedge aclk);
      areset_n = 1'b1;
      s_tdata = 32'h400;
      tick(1);
      expect_eq("post_arst_first_write", level, 1);
      idle_inputs();
      tick(1);

      // Randomized traffic, mostly well-behaved upstream with occasional violations.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (m_pstall) begin
            s_tvalid = ($urandom % 16) != 0;
            if (($urandom % 16) == 0) s_tdata = $urandom;
         end else begin
            s_tvalid = ($urandom % 4) != 0;
            s_tdata  = $urandom;
            s_tlast  = ($urandom % 3) == 0;
         end
         rd_en   = ($urandom % 5) < 2;
         clr_err = ($urandom % 20) == 0;
         tick(1);
      end
      idle_inputs();
      tick(1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
